// File: rtl/mix_columns_serial.sv
// Byte-serial AES MixColumns: collects 4-byte columns, mixes in GF(2^8), re-serialises one byte per cycle.
// Optional INV_MIX_EN adds the 'inv' port selecting InvMixColumns coefficients.
module mix_columns_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_first,
    input  logic       bypass,
`ifdef INV_MIX_EN
    input  logic       inv,
`endif
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_last,
    output logic       frame_err
);

    typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [1:0]      bc, cc;
    logic [1:0]      oc, ocol;
    logic [2:0][7:0] col_p0;
    logic [3:0][7:0] mixed_p0;
    logic [3:0][7:0] out_p1;
    logic            load_p0;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        b3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

`ifdef INV_MIX_EN
    // Inverse coefficients built from x*8 ^ x*4 ^ x*2 ^ x combinations.
    function automatic logic [7:0] mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    function automatic logic [31:0] mix_inv(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] b0, b1, b2, b3;
        b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        return {b3, b2, b1, b0};
    endfunction
`endif

    // Stage p0: column collection; the 4th byte is used live from din.
    assign load_p0 = din_valid & ~din_first & (bc == 2'd3);

    always_comb begin
        mixed_p0 = mix_fwd(col_p0[0], col_p0[1], col_p0[2], din);
`ifdef INV_MIX_EN
        if (inv)
            mixed_p0 = mix_inv(col_p0[0], col_p0[1], col_p0[2], din);
`endif
        if (bypass)
            mixed_p0 = {din, col_p0[2], col_p0[1], col_p0[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc        <= 2'd0;
            cc        <= 2'd0;
            col_p0    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= din_valid & din_first & ((bc != 2'd0) | (cc != 2'd0));
            if (din_valid) begin
                if (din_first) begin
                    col_p0[0] <= din;
                    bc        <= 2'd1;
                    cc        <= 2'd0;
                end else begin
                    case (bc)
                        2'd0:    col_p0[0] <= din;
                        2'd1:    col_p0[1] <= din;
                        2'd2:    col_p0[2] <= din;
                        default: ;
                    endcase
                    bc <= bc + 2'd1;
                    if (bc == 2'd3)
                        cc <= cc + 2'd1;
                end
            end
        end
    end

    // Stage p1: output register and serialiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load_p0) state_nxt = DRAIN;
            DRAIN:   if ((oc == 2'd3) && !load_p0) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // oc parks at 3 once drained so dout keeps showing the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            oc     <= 2'd0;
            ocol   <= 2'd0;
        end else if (load_p0) begin
            out_p1 <= mixed_p0;
            oc     <= 2'd0;
            ocol   <= cc;
        end else if ((state == DRAIN) && (oc != 2'd3)) begin
            oc <= oc + 2'd1;
        end
    end

    always_comb begin
        dout       = out_p1[oc];
        dout_valid = (state == DRAIN);
        dout_last  = (state == DRAIN) && (oc == 2'd3) && (ocol == 2'd3);
    end

endmodule

// File: tb/tb_mix_columns_serial.sv
// Bench for mix_columns_serial: directed scenarios plus random stream against a GF(2^8) matrix model.
module tb_mix_columns_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid, din_first, bypass;
    logic       inv_s;
    logic [7:0] dout;
    logic       dout_valid, dout_last, frame_err;

`ifdef INV_MIX_EN
    localparam bit INV_FEATURE = 1'b1;
`else
    localparam bit INV_FEATURE = 1'b0;
`endif

    always #5 clk = ~clk;

    mix_columns_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_first  (din_first),
        .bypass     (bypass),
`ifdef INV_MIX_EN
        .inv        (inv_s),
`endif
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .frame_err  (frame_err)
    );

    int         npass  = 0;
    int         ntotal = 0;
    int         edge_n = 0;
    logic [7:0] colq[$];
    int         col_idx;
    logic [7:0] exp_b[int];
    bit         exp_l[int];
    logic [7:0] last_dout;
    bit         fe_exp;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic model_reset();
        colq.delete();
        col_idx   = 0;
        exp_b.delete();
        exp_l.delete();
        last_dout = 8'h00;
        fe_exp    = 1'b0;
    endtask

    // Each output byte i is sum_j M[(j-i) mod 4] * a_j over GF(2^8).
    task automatic complete_column(input bit byp, input bit iv);
        logic [7:0] m[4];
        logic [7:0] r;
        if (iv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else    m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++)
                r = r ^ gmul(m[(j - i + 4) % 4], colq[j]);
            exp_b[edge_n + i] = byp ? colq[i] : r;
            exp_l[edge_n + i] = (i == 3) && (col_idx == 3);
        end
        col_idx = (col_idx + 1) % 4;
        colq.delete();
    endtask

    task automatic model_sample();
        fe_exp = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (din_valid) begin
            if (din_first) begin
                fe_exp  = (colq.size() != 0) || (col_idx != 0);
                colq.delete();
                col_idx = 0;
                colq.push_back(din);
            end else begin
                colq.push_back(din);
                if (colq.size() == 4)
                    complete_column(bypass, inv_s & INV_FEATURE);
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic check_outputs();
        if (exp_b.exists(edge_n)) begin
            check("dout_valid", {7'b0, dout_valid}, 8'h01);
            check("dout", dout, exp_b[edge_n]);
            check("dout_last", {7'b0, dout_last}, {7'b0, exp_l[edge_n]});
            last_dout = exp_b[edge_n];
            exp_b.delete(edge_n);
            exp_l.delete(edge_n);
        end else begin
            check("dout_valid_idle", {7'b0, dout_valid}, 8'h00);
            check("dout_hold", dout, last_dout);
            check("dout_last_idle", {7'b0, dout_last}, 8'h00);
        end
        check("frame_err", {7'b0, frame_err}, {7'b0, fe_exp});
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic f, input logic b);
        din       = d;
        din_valid = v;
        din_first = f;
        bypass    = b;
        @(posedge clk);
        edge_n++;
        model_sample();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_col(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] a3, input logic first, input logic byp);
        step(a0, 1'b1, first, byp);
        step(a1, 1'b1, 1'b0, byp);
        step(a2, 1'b1, 1'b0, byp);
        step(a3, 1'b1, 1'b0, byp);
    endtask

    initial begin
        rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; din_first = 1'b0; bypass = 1'b0; inv_s = 1'b0;
        model_reset();
        #1;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", {7'b0, dout_valid}, 8'h00);
        check("rst_last", {7'b0, dout_last}, 8'h00);
        check("rst_ferr", {7'b0, frame_err}, 8'h00);
        idle(2);
        rst_n = 1'b1;

        // single column, continuous
        send_col(8'hdb, 8'h13, 8'h53, 8'h45, 1'b1, 1'b0);
        idle(5);

        // full state back-to-back
        send_col(8'hdb, 8'h13, 8'h53, 8'h45, 1'b1, 1'b0);
        send_col(8'hf2, 8'h0a, 8'h22, 8'h5c, 1'b0, 1'b0);
        send_col(8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        send_col(8'h2d, 8'h26, 8'h31, 8'h4c, 1'b0, 1'b0);
        idle(5);

        // bypass then mixed
        send_col(8'hd4, 8'hd4, 8'hd4, 8'hd5, 1'b1, 1'b1);
        send_col(8'hd4, 8'hd4, 8'hd4, 8'hd5, 1'b0, 1'b0);
        idle(5);

        // gapped input
        step(8'hc6, 1'b1, 1'b1, 1'b0);
        idle(2);
        step(8'hc6, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(8'hc6, 1'b1, 1'b0, 1'b0);
        step(8'hc6, 1'b1, 1'b0, 1'b0);
        idle(6);

        // misalignment recovery
        step(8'h11, 1'b1, 1'b0, 1'b0);
        step(8'h22, 1'b1, 1'b0, 1'b0);
        send_col(8'hdb, 8'h13, 8'h53, 8'h45, 1'b1, 1'b0);
        idle(5);

        // async reset during drain at oc=1
        send_col(8'hf2, 8'h0a, 8'h22, 8'h5c, 1'b1, 1'b0);
        idle(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_valid", {7'b0, dout_valid}, 8'h00);
        check("midrst_dout", dout, 8'h00);
        idle(1);
        rst_n = 1'b1;
        send_col(8'hdb, 8'h13, 8'h53, 8'h45, 1'b1, 1'b0);
        idle(5);

        if (INV_FEATURE) begin
            inv_s = 1'b1;
            send_col(8'h8e, 8'h4d, 8'ha1, 8'hbc, 1'b1, 1'b0);
            inv_s = 1'b0;
            idle(5);
        end

        // randomized stream
        for (int k = 0; k < 600; k++) begin
            logic       v, f, b;
            logic [7:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (colq.size() == 0 && col_idx == 0) f = ($urandom_range(0, 2) == 0);
            else                                  f = ($urandom_range(0, 19) == 0);
            b = ($urandom_range(0, 3) == 0);
            inv_s = ($urandom_range(0, 1) == 1);
            step(d, v, f, b);
        end
        inv_s = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
